// File: rtl/sdram_pkg.sv
// Shared constants, types and FSM state codes for the SDRAM port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: default address/data widths, addr_t/data_t, IDLE/GRANT state codes, round-robin helper.
package sdram_pkg;

   localparam int AW_DEF = 24;   // 16M x 16-bit SDRAM word address
   localparam int DW_DEF = 16;

   typedef logic [AW_DEF-1:0] addr_t;
   typedef logic [DW_DEF-1:0] data_t;

   // Arbiter FSM states
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   // Index that follows g in round-robin order over n requesters.
   function automatic int rr_next(input int g, input int n);
      return (g + 1) % n;
   endfunction

endpackage

// File: rtl/sdram_arb_tagq.sv
// Synchronous FIFO of requester tags, one per outstanding read, returned in request order.
// Latency: push visible at head next cycle; head/full/empty are registered-state derived.
// Backpressure: push while full is accepted only together with a pop (occupancy unchanged).
// Ports: clk, reset (sync, active-high), push/push_tag, pop, head (oldest tag), full, empty.
module sdram_arb_tagq
   import sdram_pkg::*;
#(
   parameter int TW    = 1,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [TW-1:0] push_tag,
   input  logic          pop,
   output logic [TW-1:0] head,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);

   logic [TW-1:0] slots [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   // A pop frees the slot the same cycle, so a push at full is fine when paired with one.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = slots[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin burst arbiter sharing one SDRAM controller port among N requesters; routes read data back by tag.
// Latency: 1-cycle registered arbitration, then request forwarded combinationally; read return routed same cycle.
// Backpressure: mem_ready passes straight to the granted req_ready; reads also stall while every tag slot is in use.
// Ports: req_* (per-requester request, packed [N-1:0]), mem_* (controller side), rd_data/rd_valid (one-hot return),
//        grant (current/last winner, debug), err_unexp (sticky: read return with nothing outstanding).
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int N     = 2,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int BURST = 8,
   parameter int RDQ   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           req_valid,
   input  logic [N-1:0]           req_we,
   input  logic [N-1:0][AW-1:0]   req_addr,
   input  logic [N-1:0][DW-1:0]   req_data,
   output logic [N-1:0]           req_ready,
   output logic [DW-1:0]          rd_data,
   output logic [N-1:0]           rd_valid,
   output logic                   mem_valid,
   output logic                   mem_we,
   output logic [AW-1:0]          mem_addr,
   output logic [DW-1:0]          mem_data,
   input  logic                   mem_ready,
   input  logic [DW-1:0]          mem_rd_data,
   input  logic                   mem_rd_valid,
   output logic [$clog2(N)-1:0]   grant,
   output logic                   err_unexp
);

   localparam int GW = $clog2(N);
   localparam int CW = $clog2(BURST + 1);

   logic [0:0]    state;
   logic [GW-1:0] ptr;
   logic [GW-1:0] winner;
   logic [GW-1:0] g;
   logic [CW-1:0] cnt;
   logic          found;
   logic          xfer;
   logic          release_g;
   logic          tq_push;
   logic          tq_pop;
   logic          tq_full;
   logic          tq_full_eff;
   logic          tq_empty;
   logic [GW-1:0] tq_head;

   assign g = grant;

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_valid[(int'(ptr) + k) % N]) begin
            winner = GW'((int'(ptr) + k) % N);
            found  = 1'b1;
         end
      end
   end

   // A return in flight this cycle frees a tag slot, letting a read be accepted alongside it.
   assign tq_pop      = mem_rd_valid & ~tq_empty;
   assign tq_full_eff = tq_full & ~tq_pop;

   always_comb begin
      req_ready = '0;
      mem_valid = 1'b0;
      mem_we    = req_we[g];
      mem_addr  = req_addr[g];
      mem_data  = req_data[g];
      if (state == GRANT) begin
         mem_valid    = req_valid[g] & (req_we[g] | ~tq_full_eff);
         req_ready[g] = mem_ready & (req_we[g] | ~tq_full_eff);
      end
   end

   assign xfer      = mem_valid & mem_ready & req_ready[g];
   assign tq_push   = xfer & ~req_we[g];
   assign release_g = (xfer && (cnt == CW'(BURST - 1))) || !req_valid[g];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         ptr       <= '0;
         cnt       <= '0;
         err_unexp <= 1'b0;
      end else begin
         if (mem_rd_valid && tq_empty) err_unexp <= 1'b1;
         case (state)
            IDLE: begin
               if (found) begin
                  grant <= winner;
                  cnt   <= '0;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) cnt <= cnt + 1'b1;
               if (release_g) begin
                  state <= IDLE;
                  ptr   <= GW'(rr_next(int'(g), N));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sdram_arb_tagq #(
      .TW    (GW),
      .DEPTH (RDQ)
   ) u_tagq (
      .clk      (clk),
      .reset    (reset),
      .push     (tq_push),
      .push_tag (g),
      .pop      (tq_pop),
      .head     (tq_head),
      .full     (tq_full),
      .empty    (tq_empty)
   );

   always_comb begin
      rd_valid = '0;
      if (tq_pop) rd_valid[tq_head] = 1'b1;
   end

   assign rd_data = mem_rd_data;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: cycle table from reset, directed burst/read/tag-full/reset sequences, random traffic.
// Requesters and controller are modelled with queues; read ownership is tracked in request order.
module tb_sdram_arbiter;
   import sdram_pkg::*;

   localparam int N = 2, AW = 24, DW = 16, BURST = 8, RDQ = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] req_valid = '0, req_we = '0, req_ready, rd_valid;
   logic [N-1:0][AW-1:0] req_addr = '0;
   logic [N-1:0][DW-1:0] req_data = '0;
   logic [DW-1:0] rd_data, mem_data, mem_rd_data = '0;
   logic mem_valid, mem_we, mem_ready = 1'b0, mem_rd_valid = 1'b0, err_unexp;
   logic [AW-1:0] mem_addr;
   logic [0:0] grant;

   always #5 clk = ~clk;

   sdram_arbiter #(.N(N), .AW(AW), .DW(DW), .BURST(BURST), .RDQ(RDQ)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_ready(mem_ready), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .grant(grant), .err_unexp(err_unexp));

   typedef struct { logic we; addr_t addr; data_t data; } req_t;
   typedef struct { int due; data_t data; } ret_t;
   typedef struct packed {
      logic [1:0] rv; logic [1:0] we; logic mr; logic mrv;
      logic mv; logic [1:0] rr; logic g; logic [1:0] rdv; logic err;
   } vec_t;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   req_t rq [N][$];
   ret_t retq[$];
   int owners[$];
   int acc_cyc[$], acc_own[$];
   data_t rd1_data[$];
   logic [N-1:0] pres;
   int acc_cnt [N], rdv_cnt [N], streak [N];
   int p_valid, p_ready, dly_lo, dly_hi, ret_allow, nret, last_pop_cyc, last_rd_acc_cyc;
   bit force_pulse, exp_err;
   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         rq[i].delete(); acc_cnt[i] = 0; rdv_cnt[i] = 0; streak[i] = 0;
      end
      pres = '0; owners.delete(); retq.delete(); acc_cyc.delete(); acc_own.delete(); rd1_data.delete();
      nret = 0; exp_err = 0; force_pulse = 0; ret_allow = 1000000;
      last_pop_cyc = -1; last_rd_acc_cyc = -2;
      p_valid = 100; p_ready = 100; dly_lo = 5; dly_hi = 5;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; req_valid = '0; req_we = '0; mem_ready = 1'b0; mem_rd_valid = 1'b0;
      clear_model();
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_err", err_unexp, 0);
      reset = 1'b0;
   endtask

   // One clock of requester/controller behaviour plus all per-cycle rule checks.
   task automatic run_cycle();
      logic [N-1:0] acc;
      bit from_ret;
      ret_t r;
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (!pres[i] && rq[i].size() > 0 && $urandom_range(0, 99) < p_valid) pres[i] = 1'b1;
         req_valid[i] = pres[i];
         if (rq[i].size() > 0) begin
            req_we[i] = rq[i][0].we; req_addr[i] = rq[i][0].addr; req_data[i] = rq[i][0].data;
         end
      end
      mem_ready = ($urandom_range(0, 99) < p_ready);
      mem_rd_valid = 1'b0; from_ret = 0;
      if (retq.size() > 0 && retq[0].due <= cyc && ret_allow > 0) begin
         mem_rd_valid = 1'b1; mem_rd_data = retq[0].data; from_ret = 1;
      end else if (force_pulse) begin
         mem_rd_valid = 1'b1; mem_rd_data = 16'hDEAD;
      end
      @(negedge clk);
      chk("err_unexp", err_unexp, exp_err);
      if (mem_rd_valid && owners.size() > 0) begin
         chk("rd_valid", rd_valid, 32'(1) << owners[0]);
         chk("rd_data", rd_data, mem_rd_data);
         void'(owners.pop_front());
         if (from_ret) begin void'(retq.pop_front()); ret_allow--; end
         last_pop_cyc = cyc;
      end else begin
         chk("rd_valid_none", rd_valid, 0);
         if (mem_rd_valid) exp_err = 1;
      end
      for (int i = 0; i < N; i++) if (rd_valid[i]) rdv_cnt[i]++;
      if (rd_valid[1]) rd1_data.push_back(rd_data);
      acc = req_valid & req_ready;
      chk("one_accept", $countones(acc) <= 1, 1);
      chk("mem_handshake", mem_valid & mem_ready, |acc);
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            chk("mem_we", mem_we, rq[i][0].we);
            chk("mem_addr", mem_addr, rq[i][0].addr);
            chk("mem_data", mem_data, rq[i][0].data);
            if (!rq[i][0].we) begin
               chk("tag_room", owners.size() < RDQ, 1);
               owners.push_back(i);
               r.due = cyc + $urandom_range(dly_lo, dly_hi); r.data = 16'hA000 + 16'(nret);
               retq.push_back(r); nret++; last_rd_acc_cyc = cyc;
            end
            void'(rq[i].pop_front());
            pres[i] = 1'b0; acc_cnt[i]++;
            acc_cyc.push_back(cyc); acc_own.push_back(i);
            streak[i]++; streak[1-i] = 0;
            chk("burst_cap", streak[i] <= BURST, 1);
         end
      end
      // A requester only gets a bounded run while the other is continuously waiting.
      for (int i = 0; i < N; i++) if (!pres[i]) streak[1-i] = 0;
   endtask

   task automatic add_req(input int who, input logic we, input addr_t a, input data_t d);
      req_t x;
      x.we = we; x.addr = a; x.data = d;
      rq[who].push_back(x);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int bl[$];
      int run_len;
      req_t w;
      clear_model();

      // ---- cycle table from reset ----
      //          rv     we    mr   mrv  | mv   rr     g    rdv   err
      tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
      tbl[1]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
      tbl[2]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0};
      tbl[3]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0};
      tbl[4]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0};
      tbl[5]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
      tbl[6]  = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
      tbl[7]  = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0};
      tbl[8]  = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0};
      tbl[9]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
      tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
      tbl[11] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
      tbl[12] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1};
      tbl[13] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1};
      do_reset();
      req_addr[0] = 24'h000010; req_addr[1] = 24'h000020;
      for (int r = 0; r < 14; r++) begin
         @(posedge clk); #1;
         req_valid = tbl[r].rv; req_we = tbl[r].we; mem_ready = tbl[r].mr;
         mem_rd_valid = tbl[r].mrv; mem_rd_data = 16'h5A00 + 16'(r);
         @(negedge clk);
         chk($sformatf("tbl%0d_mem_valid", r), mem_valid, tbl[r].mv);
         chk($sformatf("tbl%0d_req_ready", r), req_ready, tbl[r].rr);
         chk($sformatf("tbl%0d_grant", r), grant, tbl[r].g);
         chk($sformatf("tbl%0d_rd_valid", r), rd_valid, tbl[r].rdv);
         chk($sformatf("tbl%0d_err", r), err_unexp, tbl[r].err);
         if (tbl[r].mv) chk($sformatf("tbl%0d_mem_addr", r), mem_addr, tbl[r].g ? 24'h20 : 24'h10);
         if (tbl[r].rdv != 0) chk($sformatf("tbl%0d_rd_data", r), rd_data, 16'h5A00 + 16'(r));
      end

      // ---- single writer, 20 words: bursts 8,8,4 with one bubble between ----
      do_reset();
      for (int k = 0; k < 20; k++) add_req(0, 1'b1, addr_t'(24'h000100 + k), data_t'(k));
      for (int c = 0; c < 40; c++) run_cycle();
      run_len = 0;
      for (int k = 0; k < acc_cyc.size(); k++) begin
         if (k > 0 && acc_cyc[k] != acc_cyc[k-1] + 1) begin
            bl.push_back(run_len);
            chk("t1_bubble", acc_cyc[k] - acc_cyc[k-1], 2);
            run_len = 0;
         end
         run_len++;
      end
      bl.push_back(run_len);
      chk("t1_nbursts", bl.size(), 3);
      if (bl.size() == 3) begin
         chk("t1_burst0", bl[0], 8); chk("t1_burst1", bl[1], 8); chk("t1_burst2", bl[2], 4);
      end
      chk("t1_words", acc_cnt[0], 20);
      chk("t1_req1_idle", acc_cnt[1], 0);

      // ---- both requesters continuous: 0 x8, 1 x8, 0 x8 ----
      do_reset();
      for (int k = 0; k < 24; k++) begin
         add_req(0, 1'b1, addr_t'(24'h001000 + k), data_t'(16'h1000 + k));
         add_req(1, 1'b1, addr_t'(24'h002000 + k), data_t'(16'h2000 + k));
      end
      for (int c = 0; c < 60; c++) run_cycle();
      chk("t2_count", acc_own.size() >= 24, 1);
      if (acc_own.size() >= 24)
         for (int k = 0; k < 24; k++) chk($sformatf("t2_owner%0d", k), acc_own[k], (k / 8) % 2);

      // ---- requester 1 reads, returns 5 cycles later ----
      do_reset();
      for (int k = 0; k < 8; k++) add_req(1, 1'b0, addr_t'(24'h000200 + k), 16'h0);
      for (int c = 0; c < 40; c++) run_cycle();
      chk("t3_rdv1", rdv_cnt[1], 8);
      chk("t3_rdv0", rdv_cnt[0], 0);
      for (int k = 0; k < rd1_data.size(); k++) chk($sformatf("t3_data%0d", k), rd1_data[k], 16'hA000 + k);

      // ---- tag FIFO full: reads stall, writes proceed, read rides on a pop ----
      do_reset();
      ret_allow = 0;
      for (int k = 0; k < 10; k++) add_req(0, 1'b0, addr_t'(24'h000300 + k), 16'h0);
      for (int c = 0; c < 30; c++) run_cycle();
      chk("t4_accepted", acc_cnt[0], 8);
      chk("t4_outstanding", owners.size(), 8);
      chk("t4_stall_ready", req_ready[0], 0);
      chk("t4_stall_memv", mem_valid, 0);
      w.we = 1'b1; w.addr = 24'h000777; w.data = 16'h7777;
      rq[0].push_front(w);
      for (int c = 0; c < 3; c++) run_cycle();
      chk("t4_write_acc", acc_cnt[0], 9);
      ret_allow = 1;
      for (int c = 0; c < 4; c++) run_cycle();
      chk("t4_read9_acc", acc_cnt[0], 10);
      chk("t4_same_cycle", last_rd_acc_cyc, last_pop_cyc);
      chk("t4_still_full", owners.size(), 8);

      // ---- unexpected return: sticky error until reset ----
      do_reset();
      force_pulse = 1; run_cycle(); force_pulse = 0;
      for (int c = 0; c < 3; c++) run_cycle();
      chk("t5_err_sticky", err_unexp, 1);
      do_reset();

      // ---- reset mid-burst with 3 reads outstanding ----
      ret_allow = 0;
      for (int k = 0; k < 6; k++) add_req(0, 1'b0, addr_t'(24'h000400 + k), 16'h0);
      for (int c = 0; c < 40 && acc_cnt[0] < 3; c++) run_cycle();
      chk("t6_reach3", acc_cnt[0], 3);
      @(posedge clk); #1;
      reset = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b0; mem_ready = 1'b1; mem_rd_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_mem_valid", mem_valid, 0);
      chk("t6_req_ready", req_ready, 0);
      chk("t6_grant", grant, 0);
      reset = 1'b0;
      clear_model();
      force_pulse = 1; run_cycle(); force_pulse = 0;
      run_cycle();
      chk("t6_fifo_empty", err_unexp, 1);

      // ---- random traffic against the queue model ----
      do_reset();
      p_valid = 60; p_ready = 70; dly_lo = 1; dly_hi = 6;
      for (int k = 0; k < 150; k++)
         for (int i = 0; i < N; i++)
            add_req(i, 1'($urandom_range(0, 1)), addr_t'($urandom()), data_t'($urandom()));
      for (int c = 0; c < 4000; c++) begin
         if (rq[0].size() == 0 && rq[1].size() == 0 && owners.size() == 0) break;
         run_cycle();
      end
      chk("rand_drained", rq[0].size() + rq[1].size() + owners.size(), 0);
      chk("rand_total", acc_cnt[0] + acc_cnt[1], 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
